// File: rtl/mips_mem_responder_pkg.sv
// Shared types for the MIPS memory responder: responder FSM state encoding.
package mips_mem_responder_pkg;

  typedef enum logic [1:0] {
    MS_IDLE    = 2'd0,
    MS_LOAD    = 2'd1,
    MS_RELEASE = 2'd2,
    MS_RUN     = 2'd3
  } memstate_t;

  localparam int unsigned LOAD_WIDTH = 8;

endpackage

// File: rtl/mips_mem_responder_mem_array.sv
// Byte storage: one synchronous write port, one asynchronous read port, never cleared.
module mem_array #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDRBITS = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRBITS-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDRBITS-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  localparam int unsigned DEPTH = 2**ADDRBITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: byte-stream loader, core
// read/write port and store-event reporting around a shared byte array.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDRBITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDRBITS:0]     load_count,
  output logic                  cpu_reset,
  input  logic [WIDTH-1:0]      adr,
  input  logic [WIDTH-1:0]      writedata,
  input  logic                  memread,
  input  logic                  memwrite,
  output logic [WIDTH-1:0]      memdata,
  output logic                  store_valid,
  output logic [WIDTH-1:0]      store_adr,
  output logic [WIDTH-1:0]      store_data
);

  memstate_t           state;
  logic [ADDRBITS-1:0] load_ptr;
  logic                accept;
  logic                we;
  logic [ADDRBITS-1:0] waddr;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    rdata;

  assign accept = load_valid && (state == MS_LOAD);

  // Single write port: loader owns it in LOAD, the core in RUN.
  always_comb begin
    we    = 1'b0;
    waddr = load_ptr;
    wdata = WIDTH'(load_data);
    if (accept) begin
      we = 1'b1;
    end else if ((state == MS_RUN) && memwrite) begin
      we    = 1'b1;
      waddr = adr[ADDRBITS-1:0];
      wdata = writedata;
    end
  end

  mem_array #(
    .WIDTH    (WIDTH),
    .ADDRBITS (ADDRBITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (adr[ADDRBITS-1:0]),
    .rdata (rdata)
  );

  assign memdata = ((state == MS_RUN) && memread) ? rdata : '0;

  // load_ready and cpu_reset are registered alongside state so they always match its decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= MS_IDLE;
      load_ready  <= 1'b0;
      cpu_reset   <= 1'b1;
      load_ptr    <= '0;
      load_count  <= '0;
      store_valid <= 1'b0;
      store_adr   <= '0;
      store_data  <= '0;
    end else begin
      store_valid <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (load_start) begin
            state      <= MS_LOAD;
            load_ready <= 1'b1;
            load_ptr   <= '0;
            load_count <= '0;
          end
        end
        MS_LOAD: begin
          if (accept) begin
            load_ptr   <= load_ptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (load_last || (load_ptr == '1)) begin
              state      <= MS_RELEASE;
              load_ready <= 1'b0;
            end
          end
        end
        MS_RELEASE: begin
          state     <= MS_RUN;
          cpu_reset <= 1'b0;
        end
        MS_RUN: begin
          if (memwrite) begin
            store_valid <= 1'b1;
            store_adr   <= adr;
            store_data  <= writedata;
          end
          if (load_start) begin
            state      <= MS_LOAD;
            load_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            load_ptr   <= '0;
            load_count <= '0;
          end
        end
        default: begin
          state      <= MS_IDLE;
          load_ready <= 1'b0;
          cpu_reset  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder against a byte-array reference model.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [5:0] load_count;
  logic       cpu_reset;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic       store_valid;
  logic [7:0] store_adr;
  logic [7:0] store_data;

  mips_mem_responder #(
    .WIDTH    (8),
    .ADDRBITS (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .cpu_reset   (cpu_reset),
    .adr         (adr),
    .writedata   (writedata),
    .memread     (memread),
    .memwrite    (memwrite),
    .memdata     (memdata),
    .store_valid (store_valid),
    .store_adr   (store_adr),
    .store_data  (store_data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem_model [32];
  logic [7:0] fixed_img [4] = '{8'h80, 8'h01, 8'h00, 8'h20};
  int         n_fixed = 0;
  bit         prev_wr = 1'b0;
  logic [7:0] last_adr = '0;
  logic [7:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    adr = '0; writedata = '0; memread = 1'b1; memwrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_memdata", memdata, 0);
    check("rst_load_count", load_count, 0);
    check("rst_store_valid", store_valid, 0);
    check("rst_store_adr", store_adr, 0);
    check("rst_store_data", store_data, 0);
    reset = 1'b0;
    prev_wr = 1'b0; last_adr = '0; last_data = '0;
  endtask

  // One core bus cycle in RUN; model applies the write after the edge.
  task automatic core_cycle(input logic [7:0] a, input bit rd, input bit wr, input logic [7:0] wd);
    @(negedge clk);
    adr = a; memread = rd; memwrite = wr; writedata = wd;
    load_valid = 1'b0; load_start = 1'b0; load_last = 1'b0;
    #1;
    check("memdata", memdata, rd ? mem_model[a % 32] : 8'h00);
    check("store_valid", store_valid, prev_wr);
    check("store_adr", store_adr, last_adr);
    check("store_data", store_data, last_data);
    check("run_cpu_reset", cpu_reset, 0);
    @(posedge clk);
    if (wr) begin
      mem_model[a % 32] = wd;
      last_adr = a;
      last_data = wd;
    end
    prev_wr = wr;
  endtask

  // gap_mode: 0 = byte every cycle, 1 = every other cycle, 2 = random gaps.
  task automatic load_image(input int n, input bit use_last, input int gap_mode);
    int         sent = 0;
    int         exp_n;
    bit         done = 1'b0;
    bit         v;
    logic [7:0] d;
    exp_n = (use_last && n < 32) ? n : 32;
    @(negedge clk);
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hC3; load_last = 1'b0;
    memwrite = 1'b0; memread = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      load_start = (gap_mode == 1 && cyc == 3);
      memwrite = 1'($urandom_range(0, 1)); adr = 8'($urandom); writedata = 8'($urandom);
      memread = 1'b1;
      #1;
      check("load_ready", load_ready, 1);
      check("load_count", load_count, sent);
      check("load_cpu_reset", cpu_reset, 1);
      check("load_memdata", memdata, 0);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (sent < n_fixed) ? fixed_img[sent] : 8'($urandom);
      load_valid = v; load_data = d;
      load_last = use_last && (sent == n - 1);
      @(posedge clk);
      if (v) begin
        mem_model[sent] = d;
        sent++;
        if (sent == exp_n) done = 1'b1;
      end
    end
    check("load_done", done, 1);
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b1; load_data = 8'hEE; load_last = 1'b0;
    memwrite = 1'b1; adr = 8'($urandom);
    #1;
    check("rel_load_ready", load_ready, 0);
    check("rel_cpu_reset", cpu_reset, 1);
    check("rel_load_count", load_count, exp_n);
    check("rel_memdata", memdata, 0);
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    check("run_entry_cpu_reset", cpu_reset, 0);
    check("run_entry_load_ready", load_ready, 0);
    check("run_entry_load_count", load_count, exp_n);
    load_valid = 1'b0;
    prev_wr = 1'b0;
  endtask

  initial begin
    do_reset();

    // Fixed 4-byte image then read it back.
    n_fixed = 4;
    load_image(4, 1'b1, 0);
    n_fixed = 0;
    for (int a = 0; a < 4; a++) core_cycle(8'(a), 1'b1, 1'b0, 8'h00);
    check("img_byte0", mem_model[0], 8'h80);

    // Backpressure with an ignored load_start mid-load.
    load_image(6, 1'b1, 1);
    for (int a = 0; a < 6; a++) core_cycle(8'(a), 1'b1, 1'b0, 8'h00);

    // Overflow: 40 bytes offered, no load_last.
    load_image(40, 1'b0, 2);
    core_cycle(8'd31, 1'b1, 1'b0, 8'h00);
    core_cycle(8'd0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 200; i++)
      core_cycle(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom));

    // Store event and upper-address aliasing.
    core_cycle(8'h25, 1'b0, 1'b1, 8'hA5);
    core_cycle(8'h05, 1'b1, 1'b0, 8'h00);
    check("alias_read", mem_model[5], 8'hA5);
    // Read+write together: pre-write value returned, back-to-back pulses.
    core_cycle(8'h07, 1'b1, 1'b1, 8'h3C);
    core_cycle(8'h27, 1'b1, 1'b1, 8'h4D);
    core_cycle(8'h07, 1'b1, 1'b0, 8'h00);

    // Reset mid-load after 3 bytes.
    @(negedge clk);
    memwrite = 1'b0; load_start = 1'b1; load_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_start = 1'b0; load_valid = 1'b1; load_data = 8'($urandom); load_last = 1'b0;
      mem_model[i] = load_data;
      @(posedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b1; load_data = 8'h99;
    prev_wr = 1'b0; last_adr = '0; last_data = '0;
    #1;
    check("midrst_load_ready", load_ready, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_load_count", load_count, 0);
    check("midrst_store_adr", store_adr, 0);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    check("idle_no_accept", load_count, 0);
    load_image(1, 1'b1, 0);
    for (int a = 0; a < 3; a++) core_cycle(8'(a), 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 100; i++)
      core_cycle(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
